// File: rtl/tx_lane_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : tx_lane_gearbox
//  Description : Serialises 16-bit link-layer words into 4-bit nibbles for one
//                PHY lane (chN_d). The lane emits the least-significant nibble
//                first. A 2-entry FIFO sits in front of a 16-bit shifter.
//                Between words the lane can send a training nibble, idle
//                nibbles or (optionally) PRBS7. A count of data underruns is
//                kept.
//  Optional    : define TX_LANE_GEARBOX_PRBS_EN to include the PRBS7 generator
//                and the PRBS state. Without it, prbs_en is ignored.
//  Ports       : data_tx_clk   - divided TX clock; all logic updates on the rising edge
//                resetn        - synchronous, active-low reset
//                in_data/in_valid/in_last/in_ready - word input handshake
//                train_en/train_pat - training pattern request and nibble
//                prbs_en       - PRBS7 request
//                pd            - lane power-down
//                ch_d          - registered nibble to the PHY
//                ch_active     - high while a data word is being sent
//                underrun_cnt  - saturating count of underruns
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_lane_gearbox #(
    parameter logic [3:0] IDLE_NIB = 4'b0101
) (
    input  logic        data_tx_clk,
    input  logic        resetn,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        train_en,
    input  logic [3:0]  train_pat,
    input  logic        prbs_en,
    input  logic        pd,
    output logic [3:0]  ch_d,
    output logic        ch_active,
    output logic [7:0]  underrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_DATA  = 2'd2
`ifdef TX_LANE_GEARBOX_PRBS_EN
        ,S_PRBS = 2'd3
`endif
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [15:0] r_shift;
    logic        r_cur_last;
    logic [3:0]  r_ch_d, w_ch_nxt;
    logic        r_ch_active;
    logic [7:0]  r_underrun_cnt;

    // 2-entry FIFO of {last, data}
    logic [16:0] r_mem [0:1];
    logic        r_wptr, r_rptr;
    logic [1:0]  r_count;
    logic        w_full, w_empty, w_push, w_pop, w_unr_inc, w_decide;
    logic [3:0]  w_cur_nib;

    assign w_full   = (r_count == 2'd2);
    assign w_empty  = (r_count == 2'd0);
    assign in_ready = resetn & ~pd & ~w_full;
    assign w_push   = in_valid & in_ready;

    assign w_cur_nib = r_shift[{r_idx, 2'b00} +: 4];

`ifdef TX_LANE_GEARBOX_PRBS_EN
    logic [6:0]  r_lfsr;
    logic [10:0] w_prbs_step;

    // Four steps of x^7+x^6+1; the first generated bit lands in bit 0.
    function automatic logic [10:0] f_prbs4(input logic [6:0] s);
        logic [6:0] st;
        logic [3:0] nib;
        logic       b;
        st  = s;
        nib = 4'h0;
        for (int i = 0; i < 4; i++) begin
            b      = st[6] ^ st[5];
            nib[i] = b;
            st     = {st[5:0], b};
        end
        return {nib, st};
    endfunction

    assign w_prbs_step = f_prbs4(r_lfsr);
`else
    logic w_unused_prbs_en;
    assign w_unused_prbs_en = prbs_en;
`endif

    // Next state / output nibble. The nibble is taken from the current state,
    // so a change of state becomes visible on ch_d one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx + 2'd1;
        w_pop       = 1'b0;
        w_unr_inc   = 1'b0;
        w_ch_nxt    = IDLE_NIB;
        case (r_state)
            S_IDLE:  w_ch_nxt = IDLE_NIB;
            S_TRAIN: w_ch_nxt = train_pat;
            S_DATA:  w_ch_nxt = w_cur_nib;
`ifdef TX_LANE_GEARBOX_PRBS_EN
            S_PRBS:  w_ch_nxt = w_prbs_step[10:7];
`endif
            default: w_ch_nxt = IDLE_NIB;
        endcase

        // In IDLE, decide every cycle. Otherwise decide only at the word boundary.
        w_decide = (r_state == S_IDLE) || (r_idx == 2'd3);
        if (w_decide) begin
            w_idx_nxt = 2'd0;
`ifdef TX_LANE_GEARBOX_PRBS_EN
            if (prbs_en)
                w_state_nxt = S_PRBS;
            else
`endif
            if (train_en) begin
                w_state_nxt = S_TRAIN;
            end else if (!w_empty) begin
                w_state_nxt = S_DATA;
                w_pop       = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_unr_inc   = (r_state == S_DATA) && !r_cur_last;
            end
        end
    end

    always_ff @(posedge data_tx_clk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_idx          <= 2'd0;
            r_shift        <= 16'h0000;
            r_cur_last     <= 1'b0;
            r_ch_d         <= 4'h0;
            r_ch_active    <= 1'b0;
            r_underrun_cnt <= 8'h00;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= 2'd0;
        end else if (pd) begin
            // Power-down flushes the FIFO and drops any partial word. The
            // underrun history is kept.
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_ch_d      <= 4'h0;
            r_ch_active <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ch_d      <= w_ch_nxt;
            r_ch_active <= (w_state_nxt == S_DATA);
            if (w_pop) begin
                {r_cur_last, r_shift} <= r_mem[r_rptr];
                r_rptr <= ~r_rptr;
            end
            if (w_push) begin
                r_mem[r_wptr] <= {in_last, in_data};
                r_wptr        <= ~r_wptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_unr_inc && (r_underrun_cnt != 8'hFF))
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

`ifdef TX_LANE_GEARBOX_PRBS_EN
    always_ff @(posedge data_tx_clk) begin
        if (!resetn)
            r_lfsr <= 7'h7F;
        else if (!pd && (r_state == S_PRBS))
            r_lfsr <= w_prbs_step[6:0];
    end
`endif

    assign ch_d         = r_ch_d;
    assign ch_active    = r_ch_active;
    assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tx_lane_gearbox.sv
`timescale 1ns/1ps
`default_nettype none
module tb_tx_lane_gearbox;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic        train_en = 1'b0, prbs_en = 1'b0, pd = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  train_pat = 4'h0;
    wire         in_ready, ch_active;
    wire  [3:0]  ch_d;
    wire  [7:0]  underrun_cnt;

    tx_lane_gearbox dut (
        .data_tx_clk (clk),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .train_en    (train_en),
        .train_pat   (train_pat),
        .prbs_en     (prbs_en),
        .pd          (pd),
        .ch_d        (ch_d),
        .ch_active   (ch_active),
        .underrun_cnt(underrun_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The lane is modelled as a queue of pending words plus the word that is
    // being sent. Every 4-cycle slot (or every cycle while idle), the model
    // chooses the next activity.
    localparam int M_IDLE = 0, M_TRAIN = 1, M_DATA = 2, M_PRBS = 3;
    int          m_mode = M_IDLE;
    int          m_pos  = 0;
    logic [16:0] m_q[$];
    logic [15:0] m_word = 16'h0;
    logic        m_last = 1'b0;
    logic [3:0]  e_ch   = 4'h0;
    logic        e_act  = 1'b0;
    int          e_unr  = 0;
    bit          prbs_seq [127];
    int          m_bitpos = 0;

    initial begin
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            prbs_seq[i] = s[6] ^ s[5];
            s = {s[5:0], prbs_seq[i]};
        end
    end

    always @(posedge clk) begin
        bit push_ok;
        if (!resetn) begin
            m_q.delete(); m_mode = M_IDLE; m_pos = 0;
            e_ch = 4'h0; e_act = 1'b0; e_unr = 0; m_bitpos = 0;
        end else if (pd) begin
            m_q.delete(); m_mode = M_IDLE; m_pos = 0;
            e_ch = 4'h0; e_act = 1'b0;
        end else begin
            push_ok = in_valid && (m_q.size() < 2);
            case (m_mode)
                M_TRAIN: e_ch = train_pat;
                M_DATA:  e_ch = 4'((m_word >> (4 * m_pos)) & 16'hF);
                M_PRBS: begin
                    for (int i = 0; i < 4; i++)
                        e_ch[i] = prbs_seq[(m_bitpos + i) % 127];
                    m_bitpos = (m_bitpos + 4) % 127;
                end
                default: e_ch = 4'b0101;
            endcase
            if (m_mode == M_IDLE || m_pos == 3) begin
                m_pos = 0;
`ifdef TX_LANE_GEARBOX_PRBS_EN
                if (prbs_en) m_mode = M_PRBS; else
`endif
                if (train_en) m_mode = M_TRAIN;
                else if (m_q.size() > 0) begin
                    {m_last, m_word} = m_q.pop_front();
                    m_mode = M_DATA;
                end else begin
                    if (m_mode == M_DATA && !m_last && e_unr < 255) e_unr++;
                    m_mode = M_IDLE;
                end
            end else begin
                m_pos++;
            end
            if (push_ok) m_q.push_back({in_last, in_data});
            e_act = (m_mode == M_DATA);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ch_d", 32'(ch_d), 32'(e_ch));
            chk("ch_active", 32'(ch_active), 32'(e_act));
            chk("underrun_cnt", 32'(underrun_cnt), 32'(e_unr));
            chk("in_ready", 32'(in_ready), 32'(resetn && !pd && (m_q.size() < 2)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push1(input logic [15:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] seq1 [5];
        logic [3:0] seq2 [8];
        seq1 = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h5};
        seq2 = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};

        resetn = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_ch_d", 32'(ch_d), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_ch_active", 32'(ch_active), 0);
        resetn = 1'b1;
        tick();
        chk("first_idle_nib", 32'(ch_d), 5);

        // Single word with last=1
        push1(16'hA5C3, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("single_word_nib", 32'(ch_d), 32'(seq1[i]));
        end
        chk("single_word_unr", 32'(underrun_cnt), 0);

        // Two-word burst with in_valid held
        in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
        tick();
        in_data = 16'h5678; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("burst_nib", 32'(ch_d), 32'(seq2[i]));
        end
        repeat (2) tick();

        // Underrun: the FIFO runs dry after a word with last=0
        push1(16'hFFFF, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("underrun_nib", 32'(ch_d), 32'hF);
        end
        tick();
        chk("underrun_idle", 32'(ch_d), 5);
        chk("underrun_cnt1", 32'(underrun_cnt), 1);
        for (int n = 0; n < 299; n++) begin
            push1(16'hFFFF, 1'b0);
            repeat (6) tick();
        end
        chk("underrun_sat", 32'(underrun_cnt), 32'hFF);

        // Training requested in the middle of a word
        push1(16'h1234, 1'b0);
        tick(); tick();
        train_en = 1'b1; train_pat = 4'h9;
        tick(); tick(); tick();
        chk("train_word_done", 32'(ch_d), 1);
        in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("train_nib", 32'(ch_d), 9);
        repeat (10) tick();
        train_en = 1'b0;
        repeat (12) tick();

        // Power-down while the FIFO is full and a word is mid-flight
        in_valid = 1'b1; in_last = 1'b0;
        in_data = 16'h1111; tick();
        in_data = 16'h2222; tick();
        in_data = 16'h3333; tick();
        in_valid = 1'b0;
        chk("full_not_ready", 32'(in_ready), 0);
        pd = 1'b1;
        tick();
        chk("pd_ch_d", 32'(ch_d), 0);
        chk("pd_in_ready", 32'(in_ready), 0);
        pd = 1'b0;
        tick();
        chk("pd_exit_idle", 32'(ch_d), 5);
        chk("pd_exit_ready", 32'(in_ready), 1);
        tick();
        chk("pd_fifo_empty", 32'(ch_d), 5);

        // Reset in the middle of a burst
        in_valid = 1'b1; in_data = 16'h4444; tick();
        in_data = 16'h5555; tick(); tick();
        in_valid = 1'b0;
        resetn = 1'b0;
        tick();
        chk("mrst_ch_d", 32'(ch_d), 0);
        chk("mrst_act", 32'(ch_active), 0);
        chk("mrst_unr", 32'(underrun_cnt), 0);
        resetn = 1'b1;
        tick();
        chk("mrst_idle", 32'(ch_d), 5);

        // PRBS requested straight out of reset
        prbs_en = 1'b1;
        repeat (130) tick();
        prbs_en = 1'b0;
        repeat (6) tick();

        // Randomised traffic
        for (int c = 0; c < 5000; c++) begin
            resetn    = ($urandom_range(0, 299) != 0);
            pd        = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) train_en = ~train_en;
            if ($urandom_range(0, 59) == 0) prbs_en  = ~prbs_en;
            train_pat = 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0) ^ (c[9] & c[8]);
            in_data   = 16'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_lane_gearbox.md
TX_LANE_GEARBOX -- requirements
Module: tx_lane_gearbox

Interface
REQ-001 Parameter: IDLE_NIB, 4'b0101, nibble driven on ch_d when no data, training or PRBS is active.
REQ-002 Port: data_tx_clk  in  1  divided TX clock; all logic rises on posedge.
REQ-003 Port: resetn  in  1  reset, synchronous, active-low, sampled on data_tx_clk.
REQ-004 Port: in_data  in  16  link-layer word.
REQ-005 Port: in_valid  in  1  in_data/in_last valid.
REQ-006 Port: in_last  in  1  word is last of burst.
REQ-007 Port: in_ready  out  1  block accepts word this cycle.
REQ-008 Port: train_en  in  1  request training pattern.
REQ-009 Port: train_pat  in  4  training nibble.
REQ-010 Port: prbs_en  in  1  request PRBS7 output (see Configuration).
REQ-011 Port: pd  in  1  lane power-down, same polarity as PHY reg_pd_ch bit.
REQ-012 Port: ch_d  out  4  registered nibble to PHY chN_d.
REQ-013 Port: ch_active  out  1  high while state is DATA.
REQ-014 Port: underrun_cnt  out  8  saturating underrun count.

Function
REQ-015 Handshake: word transferred on posedge where in_valid & in_ready; in_ready = ~pd & (FIFO not full), combinational from registered state only.
REQ-016 Storage: 2-entry FIFO of {in_last, in_data}; plus 16-bit shifter and 2-bit nibble index.
REQ-017 Nibble order: in_data[3:0], [7:4], [11:8], [15:12]; index advances every cycle in DATA; index 3 = word boundary.
REQ-018 States: IDLE, TRAIN, DATA, PRBS (PRBS only when compiled in); decisions taken only in IDLE or at word boundary.
REQ-019 Decision priority at boundary/IDLE: prbs_en -> PRBS; else train_en -> TRAIN; else FIFO non-empty -> DATA (pop into shifter); else IDLE.
REQ-020 Latency: word accepted at edge k into empty block in IDLE drives nibble0 on ch_d after edge k+2; nibbles 1..3 on following edges.
REQ-021 Back-to-back: FIFO non-empty at boundary -> next word's nibble0 follows nibble3 with no gap; sustained 1 word / 4 cycles.
REQ-022 TRAIN: ch_d = train_pat each cycle; 4-cycle granularity; FIFO holds contents, in_ready per REQ-015.
REQ-023 IDLE: ch_d = IDLE_NIB.
REQ-024 Underrun: at DATA boundary, FIFO empty and current word in_last=0 -> IDLE and underrun_cnt += 1, saturating at 8'hFF; in_last=1 -> IDLE without increment.
REQ-025 Simultaneous push and pop at boundary with full FIFO is legal; occupancy unchanged.
REQ-026 pd=1: next edge ch_d=4'h0, FIFO flushed, state IDLE, index 0; underrun_cnt retained; pd deassert -> IDLE_NIB next edge.
REQ-027 ch_active registered, equals (state==DATA).

Reset
REQ-028 resetn=0 at posedge: state IDLE, FIFO empty, shifter 0, index 0, ch_d=4'h0, ch_active=0, underrun_cnt=0, PRBS LFSR=7'h7F.
REQ-029 Reset mid-word discards partial word; first edge with resetn=1 drives IDLE_NIB.
REQ-030 in_ready=0 while resetn=0.

Configuration
REQ-031 Macro TX_LANE_GEARBOX_PRBS_EN defined: PRBS state present; PRBS7 x^7+x^6+1, seed 7'h7F, advanced 4 steps/cycle, ch_d = 4 output bits, oldest bit in ch_d[0]; left at boundary when prbs_en=0.
REQ-032 Macro undefined: no PRBS state or LFSR; prbs_en ignored; port still present.

Verification
REQ-033 Single word 16'hA5C3, in_last=1, from IDLE -> ch_d 3,C,5,A on edges k+2..k+5, then 5 (IDLE_NIB), underrun_cnt=0.
REQ-034 Burst 16'h1234,16'h5678 (last on 2nd) held valid -> continuous 4,3,2,1,8,7,6,5; in_ready low while FIFO full.
REQ-035 Word 16'hFFFF in_last=0 then nothing -> F,F,F,F, IDLE_NIB, underrun_cnt=1; 300 such events -> 8'hFF.
REQ-036 train_en=1, train_pat=4'h9 mid-word -> current word completes, then 9 repeated; data queued during TRAIN emitted after train_en drops.
REQ-037 pd=1 with FIFO full mid-word -> ch_d=0 next edge, in_ready=0; pd=0 -> IDLE_NIB, FIFO empty; resetn=0 mid-burst -> all REQ-028 values.
REQ-038 With TX_LANE_GEARBOX_PRBS_EN, prbs_en=1 from reset -> ch_d matches PRBS7 reference model for 127 cycles (period 127 bits); without macro -> IDLE_NIB.
